// File: rtl/response_misr.sv
// Response compactor: folds one WIDTH-bit vector per accepted handshake into a MISR,
// then flags done and compares the final signature against a golden value.
module response_misr #(
    parameter int          WIDTH       = 32,
    parameter int          NUM_VECTORS = 10000,
    parameter logic [31:0] POLY        = 32'h04C11DB7,
    parameter logic [31:0] SEED        = 32'h0,
    localparam int         CNT_W       = $clog2(NUM_VECTORS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] expected,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] count,
    output logic             done,
    output logic             pass
);

    localparam logic [WIDTH-1:0] POLY_W = WIDTH'(POLY);
    localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sig_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic             done_p1, pass_p1;
    logic             accept, last_accept, restart;
    logic [WIDTH-1:0] sig_next;

    // One MISR step: shift left, reduce by the feedback polynomial, XOR in the vector.
    function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] fb;
        fb = s[WIDTH-1] ? POLY_W : '0;
        return {s[WIDTH-2:0], 1'b0} ^ fb ^ d;
    endfunction

    assign in_ready    = (state == RUN);
    assign accept      = in_valid & in_ready;
    assign last_accept = accept & (cnt_p1 == LAST);
    assign restart     = start & ((state == IDLE) | (state == DONE));
    assign sig_next    = misr_step(sig_p1, in_data);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_accept) state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Stage p1: registered state, signature, count and completion flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sig_p1  <= SEED_W;
            cnt_p1  <= '0;
            done_p1 <= 1'b0;
            pass_p1 <= 1'b0;
        end else begin
            state <= state_next;
            if (restart) begin
                sig_p1  <= SEED_W;
                cnt_p1  <= '0;
                done_p1 <= 1'b0;
                pass_p1 <= 1'b0;
            end else if (accept) begin
                sig_p1 <= sig_next;
                cnt_p1 <= cnt_p1 + CNT_W'(1);
                if (last_accept) begin
                    done_p1 <= 1'b1;
                    pass_p1 <= (sig_next == expected);
                end
            end
        end
    end

    assign signature = sig_p1;
    assign count     = cnt_p1;
    assign done      = done_p1;
    assign pass      = pass_p1;

endmodule
